// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave register file with independent read/write paths, WSTRB byte lanes,
// SLVERR on out-of-range words and per-register write protection.
module axi4_lite_regfile_slave #(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 32,
  parameter logic [NUM_REGS-1:0] RO_MASK    = {NUM_REGS{1'b0}}
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS_WIDTH = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = ADDR_WIDTH - OFFS_WIDTH;
  localparam logic [IDX_WIDTH:0] NUM_REGS_EXT = (IDX_WIDTH + 1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  r_aw_held;
  logic [IDX_WIDTH-1:0]  r_aw_idx;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_WIDTH-1:0] r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [IDX_WIDTH-1:0]  w_wr_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_WIDTH-1:0] w_wr_strb;
  logic                  w_wr_in_range;
  logic [IDX_WIDTH-1:0]  w_rd_idx;
  logic                  w_rd_in_range;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused;

  // Byte-offset address bits select nothing inside a word.
  assign w_unused = ^{S_AWADDR[OFFS_WIDTH-1:0], S_ARADDR[OFFS_WIDTH-1:0]};

  assign S_AWREADY = !r_aw_held && !r_bvalid;
  assign S_WREADY  = !r_w_held && !r_bvalid;
  assign S_ARREADY = !r_rvalid;
  assign S_BVALID  = r_bvalid;
  assign S_BRESP   = r_bresp;
  assign S_RVALID  = r_rvalid;
  assign S_RDATA   = r_rdata;
  assign S_RRESP   = r_rresp;

  assign w_aw_hs  = S_AWVALID && S_AWREADY;
  assign w_w_hs   = S_WVALID && S_WREADY;
  assign w_ar_hs  = S_ARVALID && S_ARREADY;
  assign w_commit = (w_aw_hs || r_aw_held) && (w_w_hs || r_w_held);

  // A same-edge handshake wins over the (necessarily empty) holding register.
  assign w_wr_idx       = w_aw_hs ? S_AWADDR[ADDR_WIDTH-1:OFFS_WIDTH] : r_aw_idx;
  assign w_wr_data      = w_w_hs ? S_WDATA : r_w_data;
  assign w_wr_strb      = w_w_hs ? S_WSTRB : r_w_strb;
  assign w_wr_in_range  = {1'b0, w_wr_idx} < NUM_REGS_EXT;

  assign w_rd_idx       = S_ARADDR[ADDR_WIDTH-1:OFFS_WIDTH];
  assign w_rd_in_range  = {1'b0, w_rd_idx} < NUM_REGS_EXT;

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_idx == IDX_WIDTH'(i)) w_rd_data = r_regs[i];
    end
  end

  // NOTE: the register array is reset element by element because every register has a defined
  // reset value; a storage array without one would be left out of the reset branch.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= DATA_WIDTH'(i);
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_idx == IDX_WIDTH'(i) && !RO_MASK[i]) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_wr_strb[b]) r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_idx  <= S_AWADDR[ADDR_WIDTH-1:OFFS_WIDTH];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_w_data <= S_WDATA;
          r_w_strb <= S_WSTRB;
        end
        if (r_bvalid && S_BREADY) r_bvalid <= 1'b0;
      end
    end
  end

  // Read data samples the array before this edge's commit lands, so same-edge writes stay invisible.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_in_range ? w_rd_data : '0;
      r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rvalid && S_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed and randomized bench for axi4_lite_regfile_slave against an array-based register model.
module tb_axi4_lite_regfile_slave;

  localparam int          NREGS = 32;
  localparam logic [31:0] RO    = 32'h0000_0004;

  logic        ACLK;
  logic        ARESETN;
  logic [7:0]  S_AWADDR;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [7:0]  S_ARADDR;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [NREGS];

  axi4_lite_regfile_slave #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(NREGS), .RO_MASK(RO)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) model[i] = 32'(i);
  endfunction

  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx = int'(addr) / 4;
    if (idx >= NREGS) return 2'b10;
    if (!RO[idx]) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [7:0] addr);
    int idx = int'(addr) / 4;
    return (idx < NREGS) ? model[idx] : 32'h0;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  // Starts and ends at a falling edge; payload is scrambled whenever VALID is low.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_now, w_now;
    int cyc = 0;
    logic [1:0] exp_resp;
    S_BREADY = 1'b1;
    while (!(aw_done && w_done) && cyc < 50) begin
      S_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AWADDR  = S_AWVALID ? addr : 8'($urandom);
      S_WVALID  = !w_done && (cyc >= w_dly);
      S_WDATA   = S_WVALID ? data : $urandom;
      S_WSTRB   = S_WVALID ? strb : 4'($urandom);
      check("bvalid_before_commit", 32'(S_BVALID), 32'h0);
      aw_now = S_AWVALID && S_AWREADY;
      w_now  = S_WVALID && S_WREADY;
      tick();
      if (aw_now) aw_done = 1;
      if (w_now)  w_done  = 1;
      cyc++;
    end
    S_AWVALID = 1'b0;
    S_WVALID  = 1'b0;
    check("wr_handshake_bound", 32'(aw_done && w_done), 32'h1);
    exp_resp = model_write(addr, data, strb);
    check("bvalid_after_commit", 32'(S_BVALID), 32'h1);
    check("bresp", 32'(S_BRESP), 32'(exp_resp));
    tick();
    check("bvalid_cleared", 32'(S_BVALID), 32'h0);
  endtask

  task automatic axi_read(input logic [7:0] addr);
    S_RREADY  = 1'b1;
    S_ARVALID = 1'b1;
    S_ARADDR  = addr;
    check("arready", 32'(S_ARREADY), 32'h1);
    tick();
    S_ARVALID = 1'b0;
    S_ARADDR  = 8'($urandom);
    check("rvalid", 32'(S_RVALID), 32'h1);
    check("rdata", S_RDATA, model_rdata(addr));
    check("rresp", 32'(S_RRESP), (int'(addr) / 4 < NREGS) ? 32'h0 : 32'h2);
    tick();
    check("rvalid_cleared", 32'(S_RVALID), 32'h0);
  endtask

  initial begin
    ARESETN = 1'b0;
    S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0;
    S_BREADY = 1'b0; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;
    model_reset();
    repeat (3) @(negedge ACLK);
    check("rst_bvalid", 32'(S_BVALID), 32'h0);
    check("rst_rvalid", 32'(S_RVALID), 32'h0);
    check("rst_bresp", 32'(S_BRESP), 32'h0);
    check("rst_rresp", 32'(S_RRESP), 32'h0);
    check("rst_rdata", S_RDATA, 32'h0);
    ARESETN = 1'b1;
    tick();
    check("awready_after_rst", 32'(S_AWREADY), 32'h1);
    check("wready_after_rst", 32'(S_WREADY), 32'h1);
    check("arready_after_rst", 32'(S_ARREADY), 32'h1);

    axi_read(8'h0C);
    // Register 2 is write-protected here, so the full-word write goes to register 6.
    axi_write(8'h18, 32'hDEAD_BEEF, 4'hF, 0, 0);
    axi_read(8'h18);
    axi_write(8'h10, 32'h1122_3344, 4'h5, 3, 0);
    axi_read(8'h10);
    check("reg4_partial", model[4], 32'h0022_0044);
    axi_write(8'h80, 32'hCAFE_F00D, 4'hF, 0, 0);
    axi_read(8'h80);
    axi_write(8'h08, 32'hFFFF_FFFF, 4'hF, 1, 2);
    axi_read(8'h08);
    axi_write(8'h1B, 32'h0000_5A00, 4'h2, 0, 1);
    axi_read(8'h18);

    // Stalled write response with a new AW pending and a concurrent read.
    S_BREADY = 1'b0;
    S_AWVALID = 1'b1; S_AWADDR = 8'h20;
    S_WVALID = 1'b1; S_WDATA = 32'hA5A5_A5A5; S_WSTRB = 4'hF;
    check("stall_awready0", 32'(S_AWREADY), 32'h1);
    tick();
    void'(model_write(8'h20, 32'hA5A5_A5A5, 4'hF));
    S_WVALID = 1'b0;
    S_AWADDR = 8'h24;
    for (int k = 0; k < 5; k++) begin
      check("stall_bvalid", 32'(S_BVALID), 32'h1);
      check("stall_awready", 32'(S_AWREADY), 32'h0);
      check("stall_wready", 32'(S_WREADY), 32'h0);
      if (k == 0) begin
        S_ARVALID = 1'b1; S_ARADDR = 8'h04; S_RREADY = 1'b1;
        check("stall_arready", 32'(S_ARREADY), 32'h1);
      end else if (k == 1) begin
        S_ARVALID = 1'b0;
        check("stall_rvalid", 32'(S_RVALID), 32'h1);
        check("stall_rdata", S_RDATA, 32'h1);
        check("stall_rresp", 32'(S_RRESP), 32'h0);
      end else if (k == 2) begin
        check("stall_rvalid_clr", 32'(S_RVALID), 32'h0);
      end
      tick();
    end
    #2 ARESETN = 1'b0;
    #1;
    check("abort_bvalid", 32'(S_BVALID), 32'h0);
    check("abort_rvalid", 32'(S_RVALID), 32'h0);
    S_AWVALID = 1'b0;
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
    check("abort_no_bvalid", 32'(S_BVALID), 32'h0);
    axi_read(8'h20);
    axi_read(8'h18);
    axi_read(8'h10);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] wa, ra;
      wa = 8'($urandom_range(0, 159));
      ra = 8'($urandom_range(0, 159));
      axi_write(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      axi_read(wa);
      axi_read(ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
